regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Shares the single register-file write port (write_enable/A3/WD) between N_REQ writeback
//  sources (ALU, LSU, MDU) using round-robin arbitration, with a registered output stage.
//  Keeps a 32-entry pending-write scoreboard so issue logic stalls on RAW/WAW hazards
//  until the register-file write has committed. Sits between the execute units and reg_file.
// PARAMETERS
//  XLEN   32  data width of writeback values
//  N_REQ  3   number of writeback requesters (2..8)
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  reset      in   1           asynchronous, active-high reset
//  req_valid  in   N_REQ       requester i has a writeback pending
//  req_rd     in   N_REQ*5     dest reg of requester i, bits [5i+4:5i]
//  req_data   in   N_REQ*XLEN  result of requester i, bits [XLEN*i+XLEN-1:XLEN*i]
//  req_ready  out  N_REQ       one-hot grant; writeback i accepted this cycle
//  iss_valid  in   1           issue stage dispatching an instr that writes iss_rd
//  iss_rd     in   5           dest reg of instr being issued
//  iss_rs1    in   5           source reg 1 of instr at issue
//  iss_rs2    in   5           source reg 2 of instr at issue
//  iss_stall  out  1           busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd] (combinational)
//  rf_we      out  1           to reg_file write_enable (registered)
//  rf_waddr   out  5           to reg_file A3 (registered)
//  rf_wdata   out  XLEN        to reg_file WD (registered)
//  busy_vec   out  32          scoreboard state, bit r = write to xr pending
// BEHAVIOUR
//  Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, rr pointer=0; req_ready=0
//    and iss_stall=0 while reset is high. Reset mid-operation drops all pending grants/busy bits.
//  Handshake: req_valid must not depend on req_ready; requester holds valid/rd/data stable
//    until req_ready&req_valid. Transfer occurs on the edge where both are high.
//  Arbitration (combinational, cycle T): search from ptr upward mod N_REQ; first valid wins;
//    req_ready is one-hot or zero. On grant to i, ptr <= (i+1) mod N_REQ; no grant, ptr holds.
//    Output stage never back-pressures: one grant per cycle maximum.
//  Latency: grant in cycle T -> rf_we=1, rf_waddr, rf_wdata valid in cycle T+1; reg_file
//    commits at end of T+1. No grant in T -> rf_we=0 in T+1 (waddr/wdata hold last value).
//  x0: grant to rd=0 is accepted (ready=1) but rf_we stays 0 in T+1; busy[0] is constant 0.
//  Scoreboard: set busy[iss_rd] on edge when iss_valid & !iss_stall & iss_rd!=0.
//    Clear busy[r] on the edge ending cycle T+1 (same edge reg_file commits r).
//    Set and clear of same r on the same edge: set wins (busy stays 1).
//    iss_stall ignores rs/rd fields equal to 0. iss_valid with iss_stall=1 changes nothing.
//  Because WAW stalls, at most one write per register is outstanding; a writeback to a
//    non-busy rd!=0 is still forwarded to reg_file (no assertion in RTL; checked in bench).
//  State: 32-bit busy vector, ptr ($clog2(N_REQ) bits), output register; no other FSM.
// TESTING
//  1 Assert reset mid-stream with rf_we=1 and busy_vec=0x0000_0024 -> immediately rf_we=0,
//    busy_vec=0, req_ready=0; after release first grant goes to requester 0.
//  2 iss x5 (valid), next cycle req_valid=3'b001 rd=5 data=0xDEADBEEF -> req_ready=001 same
//    cycle; rf_we=1 A3=5 WD=0xDEADBEEF next cycle; busy_vec[5] clears on that edge.
//  3 req_valid=3'b111 held 3 cycles (ptr=0), requesters drop valid once accepted ->
//    grants 001,010,100 in order; 4th cycle with all valid again -> 001.
//  4 req_valid=3'b010 rd=0 data=0x1234 -> req_ready=010, rf_we stays 0, busy_vec unchanged.
//  5 busy[7]=1, iss_rs2=7 -> iss_stall=1 until cycle after rf_we with A3=7; iss_rd=7 with
//    iss_valid while stalled -> busy unchanged.
//  6 Writeback of x9 commits on same edge iss_valid sets x9 (stall blocked via x9 busy? no:
//    use iss_rd=9 after clear requested) -> busy_vec[9]=1 after edge (set beats clear).

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter sharing the register-file write port between writeback units,
// with a registered write stage and a pending-write scoreboard for issue hazard stalls.
module regfile_wb_scheduler #(
    parameter int XLEN  = 32,
    parameter int N_REQ = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*5-1:0]    req_rd,
    input  logic [N_REQ*XLEN-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    input  logic [4:0]            iss_rs1,
    input  logic [4:0]            iss_rs2,
    output logic                  iss_stall,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [31:0]           busy_vec
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;
    logic [31:0]     busy_next;
    logic            iss_fire;

    // Rotating priority search starting at ptr; first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        grant_rd   = '0;
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PW'(i)) begin
                grant_rd   = req_rd[i*5 +: 5];
                grant_data = req_data[i*XLEN +: XLEN];
                req_ready[i] = grant_any && !reset;
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (grant_any) begin
            ptr_next = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_comb begin
        iss_stall = 1'b0;
        if (!reset) begin
            iss_stall = ((iss_rs1 != 5'd0) && busy_vec[iss_rs1]) ||
                        ((iss_rs2 != 5'd0) && busy_vec[iss_rs2]) ||
                        ((iss_rd  != 5'd0) && busy_vec[iss_rd]);
        end
    end

    assign iss_fire = iss_valid && !iss_stall && (iss_rd != 5'd0);

    // Clear on commit first so a same-edge set of the same register wins.
    always_comb begin
        busy_next = busy_vec;
        if (rf_we) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (iss_fire) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy_vec <= '0;
        end else begin
            ptr      <= ptr_next;
            busy_vec <= busy_next;
            rf_we    <= grant_any && (grant_rd != 5'd0);
            if (grant_any) begin
                rf_waddr <= grant_rd;
                rf_wdata <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration order, write latency, x0 handling,
// scoreboard set/clear/stall behaviour and asynchronous reset.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        iss_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_wb_scheduler #(.XLEN(32), .N_REQ(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_stall (iss_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] v,
                           input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        req_valid = v;
        req_rd    = {r2, r1, r0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic set_iss(input logic v, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
        iss_valid = v;
        iss_rd    = rd;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
    endtask

    initial begin
        reset = 1'b1;
        set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0);
        set_iss(1'b1, 5'd4, 5'd0, 5'd0);
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_stall", 32'(iss_stall), 32'h0);
        step();
        step();
        chk("rst_busy_hold", busy_vec, 32'h0);
        set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;

        // Round-robin order with ptr=0
        step();
        set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hB2, 32'hC3);
        #1;
        chk("rr_g1", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b110;
        #1;
        chk("rr_g2", 32'(req_ready), 32'h2);
        chk("rr_we1", 32'(rf_we), 32'h1);
        chk("rr_a1", 32'(rf_waddr), 32'd1);
        chk("rr_d1", rf_wdata, 32'hA1);
        step();
        req_valid = 3'b100;
        #1;
        chk("rr_g3", 32'(req_ready), 32'h4);
        chk("rr_a2", 32'(rf_waddr), 32'd2);
        chk("rr_d2", rf_wdata, 32'hB2);
        step();
        req_valid = 3'b111;
        #1;
        chk("rr_g4", 32'(req_ready), 32'h1);
        chk("rr_a3", 32'(rf_waddr), 32'd3);
        chk("rr_d3", rf_wdata, 32'hC3);
        step();
        req_valid = 3'b000;
        #1;
        chk("rr_none", 32'(req_ready), 32'h0);
        chk("rr_a4", 32'(rf_waddr), 32'd1);
        step();
        chk("rr_we_idle", 32'(rf_we), 32'h0);
        chk("rr_a_hold", 32'(rf_waddr), 32'd1);
        chk("rr_busy", busy_vec, 32'h0);

        // Issue x5, then writeback via requester 0 (ptr=1, wraps to 0)
        set_iss(1'b1, 5'd5, 5'd0, 5'd0);
        #1;
        chk("x5_stall0", 32'(iss_stall), 32'h0);
        step();
        chk("x5_busy", busy_vec, 32'h20);
        set_iss(1'b0, 5'd0, 5'd5, 5'd0);
        set_req(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        #1;
        chk("x5_stall_rs1", 32'(iss_stall), 32'h1);
        chk("x5_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b000;
        #1;
        chk("x5_we", 32'(rf_we), 32'h1);
        chk("x5_a3", 32'(rf_waddr), 32'd5);
        chk("x5_wd", rf_wdata, 32'hDEADBEEF);
        chk("x5_busy_pend", busy_vec, 32'h20);
        step();
        chk("x5_busy_clr", busy_vec, 32'h0);
        chk("x5_stall_clr", 32'(iss_stall), 32'h0);

        // Writeback to x0 (ptr=1) and issue to x0
        set_iss(1'b1, 5'd0, 5'd0, 5'd0);
        set_req(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0);
        #1;
        chk("x0_ready", 32'(req_ready), 32'h2);
        step();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        req_valid = 3'b000;
        #1;
        chk("x0_we", 32'(rf_we), 32'h0);
        chk("x0_busy", busy_vec, 32'h0);

        // Hazard on x7 (ptr=2)
        set_iss(1'b1, 5'd7, 5'd0, 5'd0);
        step();
        chk("x7_busy", busy_vec, 32'h80);
        set_iss(1'b1, 5'd7, 5'd0, 5'd7);
        #1;
        chk("x7_stall", 32'(iss_stall), 32'h1);
        step();
        chk("x7_busy_same", busy_vec, 32'h80);
        set_iss(1'b1, 5'd11, 5'd0, 5'd7);
        step();
        chk("x7_stalled_iss", busy_vec, 32'h80);
        set_iss(1'b0, 5'd0, 5'd0, 5'd7);
        set_req(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77);
        #1;
        chk("x7_ready", 32'(req_ready), 32'h4);
        chk("x7_stall_g", 32'(iss_stall), 32'h1);
        step();
        req_valid = 3'b000;
        #1;
        chk("x7_we", 32'(rf_we), 32'h1);
        chk("x7_a3", 32'(rf_waddr), 32'd7);
        chk("x7_stall_wb", 32'(iss_stall), 32'h1);
        step();
        chk("x7_busy_clr", busy_vec, 32'h0);
        chk("x7_stall_clr", 32'(iss_stall), 32'h0);

        // Set and clear of x9 on the same edge (ptr=0)
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        set_req(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0);
        #1;
        chk("x9_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b000;
        set_iss(1'b1, 5'd9, 5'd0, 5'd0);
        #1;
        chk("x9_we", 32'(rf_we), 32'h1);
        chk("x9_stall", 32'(iss_stall), 32'h0);
        step();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("x9_set_wins", busy_vec, 32'h200);
        step();
        chk("x9_still", busy_vec, 32'h200);

        // Mid-stream reset: busy=0x24, rf_we=1 (ptr=1 -> x9 retire first)
        set_req(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h9, 32'h0);
        step();
        req_valid = 3'b000;
        #1;
        chk("mr_busy9_pend", busy_vec, 32'h200);
        step();
        set_iss(1'b1, 5'd2, 5'd0, 5'd0);
        step();
        set_iss(1'b1, 5'd5, 5'd0, 5'd0);
        step();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0);
        chk("mr_busy", busy_vec, 32'h24);
        set_req(3'b001, 5'd1, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0);
        #1;
        chk("mr_ready_pre", 32'(req_ready), 32'h1);
        step();
        set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        #1;
        chk("mr_we_pre", 32'(rf_we), 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_we", 32'(rf_we), 32'h0);
        chk("mr_busy_clr", busy_vec, 32'h0);
        chk("mr_ready", 32'(req_ready), 32'h0);
        chk("mr_waddr", 32'(rf_waddr), 32'h0);
        chk("mr_wdata", rf_wdata, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("mr_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b000;
        #1;
        chk("mr_after_we", 32'(rf_we), 32'h1);
        chk("mr_after_a3", 32'(rf_waddr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
